leaf_stream_fifo: RTL and testbench



---
 rtl/leaf_stream_fifo.sv | 81 ++++++++
 tb/tb_leaf_stream_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/leaf_stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, plus live and peak occupancy.
// Latency: a pushed word shows on out_data one cycle later. in_ready/out_valid come from registered count only.
module leaf_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     max_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              push;
  logic              pop;
  logic [CW-1:0]     count_nxt;

  // A pop while full does not free a slot for the same cycle.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      max_count <= '0;
    end else if (clr) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      max_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      if (count_nxt > max_count) begin
        max_count <= count_nxt;
      end
    end
  end

  // Storage is wiped by reset but deliberately kept across clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (!clr && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Randomised and directed bench for leaf_stream_fifo, checked against a queue-based reference model.
module tb_leaf_stream_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     count;
  logic [CW-1:0]     max_count;

  int checks = 0;
  int errors = 0;

  int q[$];
  int mmax = 0;

  leaf_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count),
    .max_count(max_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " in_ready"}, int'(in_ready), 1);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " out_data"}, int'(out_data), 0);
    chk({tag, " count"}, int'(count), 0);
    chk({tag, " max_count"}, int'(max_count), 0);
  endtask

  // Monitor + reference model: compare the state the DUT presents, then advance the model
  // with the inputs that will be seen at the next rising edge.
  always @(negedge clk) begin
    bit m_push;
    bit m_pop;
    if (!rst_n) begin
      check_reset_outputs("reset");
      q.delete();
      mmax = 0;
    end else begin
      chk("count", int'(count), q.size());
      chk("max_count", int'(max_count), mmax);
      chk("in_ready", int'(in_ready), (q.size() < DEPTH) ? 1 : 0);
      chk("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) chk("out_data", int'(out_data), q[0]);
      if (clr) begin
        q.delete();
        mmax = 0;
      end else begin
        m_push = in_valid && (q.size() < DEPTH);
        m_pop  = out_ready && (q.size() > 0);
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(int'(in_data));
        if (q.size() > mmax) mmax = q.size();
      end
    end
  end

  task automatic step(input bit v, input int d, input bit r, input bit c);
    in_valid  = v;
    in_data   = DATA_W'(d);
    out_ready = r;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t, required earlier finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // Fill to full, then a pop while full must not let the push through.
    step(1, 'h11, 0, 0);
    step(1, 'h22, 0, 0);
    step(1, 'h33, 0, 0);
    step(1, 'h44, 0, 0);
    chk("full count", int'(count), 4);
    chk("full in_ready", int'(in_ready), 0);
    step(1, 'h55, 1, 0);
    chk("full+pop count", int'(count), 3);
    step(1, 'h55, 0, 0);
    chk("refill count", int'(count), 4);
    repeat (5) step(0, 0, 1, 0);
    chk("drained out_valid", int'(out_valid), 0);

    // Flush at count 3 with a push and pop in the same cycle.
    step(1, 'hA1, 0, 0);
    step(1, 'hA2, 0, 0);
    step(1, 'hA3, 0, 0);
    step(1, 'hEE, 1, 1);
    chk("flush count", int'(count), 0);
    chk("flush max_count", int'(max_count), 0);
    chk("flush out_valid", int'(out_valid), 0);
    step(0, 0, 0, 0);

    // Streaming through the wrap with both sides active.
    for (int i = 0; i < 10; i++) step(1, i, 1, 0);
    step(0, 0, 1, 0);
    chk("stream max_count", int'(max_count), 1);
    step(0, 0, 0, 0);

    // Asynchronous reset between edges with two words stored.
    step(1, 'h61, 0, 0);
    step(1, 'h62, 0, 0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 'hA5, 0, 0);
    chk("post-reset out_data", int'(out_data), 'hA5);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 255),
           $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
    end
    repeat (6) step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
